// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_dp_pipe dual-port memory.
// Word-wide helpers work on MAX_DATA bits; callers widen their inputs and narrow the result with size casts.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int MAX_DATA  = 1024;
  localparam int MAX_BYTES = MAX_DATA / 8;

  function automatic int byte_count(input int data_size);
    return data_size / 8;
  endfunction

  function automatic logic [MAX_DATA-1:0] byte_merge(input logic [MAX_DATA-1:0]  old_word,
                                                     input logic [MAX_DATA-1:0]  new_word,
                                                     input logic [MAX_BYTES-1:0] be);
    logic [MAX_DATA-1:0] merged;
    for (int i = 0; i < MAX_BYTES; i++)
      merged[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return merged;
  endfunction

  // Even parity per byte: the stored bit makes each 9-bit group have an even count of ones.
  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA-1:0] word);
    logic [MAX_BYTES-1:0] par;
    for (int i = 0; i < MAX_BYTES; i++)
      par[i] = ^word[i*8 +: 8];
    return par;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return register chain of RD_LATENCY stages (1 or 2) carrying data and valid.
// Each stage only reloads its data when valid, so the output holds its last word between reads.
module ram_rd_pipe #(
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vld_p0,
  input  logic [WIDTH-1:0] data_p0,
  output logic             rvalid,
  output logic [WIDTH-1:0] rdata
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  // p0 -> p1: word captured in the same cycle the read is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= data_p0;
    end
  end

  if (RD_LATENCY == 2) begin : g_two_stage
    logic             vld_p2;
    logic [WIDTH-1:0] data_p2;

    // p1 -> p2: pure retiming, later writes cannot reach a word already in p1
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p2  <= 1'b0;
        data_p2 <= '0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) data_p2 <= data_p1;
      end
    end

    assign rvalid = vld_p2;
    assign rdata  = data_p2;
  end else begin : g_one_stage
    assign rvalid = vld_p1;
    assign rdata  = data_p1;
  end

endmodule

// File: rtl/ram_dp_pipe.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, pipelined reads,
// clear-after-reset sequencer and A-write to B-read forwarding. Optional parity: RAM_PARITY_EN.
module ram_dp_pipe
  import ram_pkg::*;
#(
  parameter int ADDR_SIZE  = 10,
  parameter int DATA_SIZE  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   init_busy,
  input  logic [ADDR_SIZE-1:0]   a_addr,
  input  logic [DATA_SIZE-1:0]   a_wdata,
  input  logic [DATA_SIZE/8-1:0] a_be,
  input  logic                   a_we,
  input  logic                   a_re,
  output logic [DATA_SIZE-1:0]   a_rdata,
  output logic                   a_rvalid,
  input  logic [ADDR_SIZE-1:0]   b_addr,
  input  logic                   b_re,
  output logic [DATA_SIZE-1:0]   b_rdata,
  output logic                   b_rvalid,
  output logic                   collision
`ifdef RAM_PARITY_EN
  ,
  output logic                   a_perr,
  output logic                   b_perr
`endif
);

  localparam int BYTES = byte_count(DATA_SIZE);
  localparam int DEPTH = 2 ** ADDR_SIZE;
`ifdef RAM_PARITY_EN
  localparam int PIPE_W = DATA_SIZE + 1;
`else
  localparam int PIPE_W = DATA_SIZE;
`endif

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_dp_pipe: RD_LATENCY must be 1 or 2");
  end
  if (DATA_SIZE % 8 != 0 || DATA_SIZE > MAX_DATA) begin : g_bad_width
    $error("ram_dp_pipe: DATA_SIZE must be a multiple of 8 and at most MAX_DATA");
  end

  clr_state_e           state;
  clr_state_e           state_next;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 clr_we;
  logic                 clr_last;
  logic                 ready;

  assign clr_last = (clr_addr == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (clr_we && !clr_last) clr_addr <= clr_addr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    clr_we     = 1'b0;
    ready      = 1'b0;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        if (clr_last) state_next = READY;
      end
      READY:   ready = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic                 wr_ok;
  logic                 fwd_b;
  logic                 a_vld_p0;
  logic                 b_vld_p0;
  logic [DATA_SIZE-1:0] a_old;
  logic [DATA_SIZE-1:0] merged;
  logic [DATA_SIZE-1:0] a_word_p0;
  logic [DATA_SIZE-1:0] b_word_p0;

  assign wr_ok     = ready & a_we;
  assign a_vld_p0  = ready & a_re;
  assign b_vld_p0  = ready & b_re;
  assign fwd_b     = wr_ok & (a_addr == b_addr);
  assign a_old     = mem[a_addr];
  assign merged    = DATA_SIZE'(byte_merge(MAX_DATA'(a_old), MAX_DATA'(a_wdata), MAX_BYTES'(a_be)));
  // Write-first on A; B sees the merged word when A writes the same address
  assign a_word_p0 = wr_ok ? merged : a_old;
  assign b_word_p0 = fwd_b ? merged : mem[b_addr];

  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr] <= '0;
    else if (wr_ok) mem[a_addr]   <= merged;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) collision <= 1'b0;
    else          collision <= fwd_b & b_vld_p0;
  end

  logic [PIPE_W-1:0] a_in_p0;
  logic [PIPE_W-1:0] b_in_p0;
  logic [PIPE_W-1:0] a_out;
  logic [PIPE_W-1:0] b_out;

`ifdef RAM_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
  logic [BYTES-1:0] par_new;
  logic [BYTES-1:0] par_merged;
  logic [BYTES-1:0] a_par_p0;
  logic [BYTES-1:0] b_par_p0;
  logic             a_perr_p0;
  logic             b_perr_p0;

  // Unenabled bytes keep their stored parity so an existing corruption stays detectable
  assign par_new    = BYTES'(byte_parity(MAX_DATA'(a_wdata)));
  assign par_merged = (par_new & a_be) | (par_mem[a_addr] & ~a_be);
  assign a_par_p0   = wr_ok ? par_merged : par_mem[a_addr];
  assign b_par_p0   = fwd_b ? par_merged : par_mem[b_addr];
  assign a_perr_p0  = |(a_par_p0 ^ BYTES'(byte_parity(MAX_DATA'(a_word_p0))));
  assign b_perr_p0  = |(b_par_p0 ^ BYTES'(byte_parity(MAX_DATA'(b_word_p0))));

  always_ff @(posedge clk) begin
    if (clr_we)     par_mem[clr_addr] <= '0;
    else if (wr_ok) par_mem[a_addr]   <= par_merged;
  end

  assign a_in_p0 = {a_perr_p0, a_word_p0};
  assign b_in_p0 = {b_perr_p0, b_word_p0};
  assign a_perr  = a_rvalid & a_out[DATA_SIZE];
  assign b_perr  = b_rvalid & b_out[DATA_SIZE];
`else
  assign a_in_p0 = a_word_p0;
  assign b_in_p0 = b_word_p0;
`endif

  ram_rd_pipe #(
    .WIDTH      (PIPE_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_a_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_p0  (a_vld_p0),
    .data_p0 (a_in_p0),
    .rvalid  (a_rvalid),
    .rdata   (a_out)
  );

  ram_rd_pipe #(
    .WIDTH      (PIPE_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_b_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .vld_p0  (b_vld_p0),
    .data_p0 (b_in_p0),
    .rvalid  (b_rvalid),
    .rdata   (b_out)
  );

  assign a_rdata = a_out[DATA_SIZE-1:0];
  assign b_rdata = b_out[DATA_SIZE-1:0];

endmodule

// File: doc/ram_dp_pipe.md
Name: ram_dp_pipe

Overview:
Parametrised dual-port synchronous RAM, the next generation of the team's single-clock scratch memory. Port A is read/write with byte enables and port B is read-only. Both ports have a configurable read pipeline with valid flags. A built-in clear sequencer zeroes the array after reset, and same-address write/read pairs are resolved by defined forwarding. It serves as a frame/line buffer between the bus-side writer and the video-side reader.

Parameters:
ADDR_SIZE, 10, address width; depth = 2**ADDR_SIZE words
DATA_SIZE, 32, word width; must be a multiple of 8
RD_LATENCY, 1, cycles from accepted read to rvalid; legal values 1 or 2 (elaboration error otherwise)

Ports:
clk  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
init_busy  out  1  high while the clear sequencer runs; requests ignored
a_addr  in  ADDR_SIZE  port A address
a_wdata  in  DATA_SIZE  port A write data
a_be  in  DATA_SIZE/8  port A byte enables (bit i -> byte i)
a_we  in  1  port A write strobe
a_re  in  1  port A read strobe
a_rdata  out  DATA_SIZE  port A read data
a_rvalid  out  1  a_rdata valid, one-cycle pulse per read
b_addr  in  ADDR_SIZE  port B address
b_re  in  1  port B read strobe
b_rdata  out  DATA_SIZE  port B read data
b_rvalid  out  1  b_rdata valid, one-cycle pulse per read
collision  out  1  one-cycle pulse: A write and B read hit the same address in the same cycle

Behaviour:
- Reset (reset_n low, async): a_rdata = b_rdata = 0, a_rvalid = b_rvalid = collision = 0, init_busy = 1, read pipelines flushed, clear address = 0.
- Clear FSM states:
  - CLEAR: writes 0 to the address held in the clear counter each cycle, then increments. After address 2**ADDR_SIZE-1 is written, go to READY. This takes exactly 2**ADDR_SIZE cycles after reset release.
  - READY: init_busy = 0; normal operation; stays in READY until the next reset.
- In CLEAR, a_we, a_re and b_re are ignored, and no rvalid is produced.
- Reset asserted mid-CLEAR or mid-read: all in-flight reads are dropped (no rvalid) and CLEAR restarts at address 0.
- Write (READY, a_we=1): for each byte i with a_be[i]=1, mem[a_addr] byte i <= a_wdata byte i; other bytes keep their value. a_we with a_be=0 is a no-op.
- Read accepted when x_re=1 in READY.
  - x_rvalid = 1 exactly RD_LATENCY cycles later, for one cycle.
  - x_rdata holds its last value until the next rvalid.
  - Back-to-back reads are accepted every cycle (full throughput).
- Port A read and write in the same cycle: write-first. a_rdata returns the merged word (new enabled bytes plus old unenabled bytes).
- A write and B read to the same address in the same cycle: B also receives the merged new word (forwarded). collision = 1 on the cycle after acceptance, independent of RD_LATENCY.
- A write to a different address concurrent with B read: no interaction.
- For RD_LATENCY=2, the second stage is a pure register on data and valid. A write landing between the two stages does not alter the data already captured.
- Address wrap: none. Addresses are absolute and the clear counter saturates into READY.

Optional Feature:
RAM_PARITY_EN
- With the macro defined: one even-parity bit is stored per byte, computed on write. Parity is checked on read, and new outputs a_perr and b_perr pulse alongside the corresponding rvalid if any byte mismatches. The clear sequencer writes parity 0 (consistent with zero data).
- Without the macro: no parity storage and no perr ports.

Decomposition:
- Package ram_pkg holds:
  - the clear FSM state enum (CLEAR, READY)
  - a localparam function computing byte count from DATA_SIZE
  - a byte-merge function (old, new, be -> merged), shared by write and forwarding paths
- One sub-module is natural: ram_rd_pipe, a RD_LATENCY-stage data+valid register chain instantiated once per port.

Test Plan:
- ADDR_SIZE=4: release reset -> init_busy high exactly 16 cycles; a_re to addr 5 right after -> a_rdata=0x00000000 with a_rvalid after RD_LATENCY.
- Write addr 3 = 0xDEADBEEF be=0xF, then write addr 3 = 0x11223344 be=0x5 -> read gives 0xDE22BE44.
- Same cycle: a_we addr 7 = 0xCAFEF00D be=0xF and b_re addr 7 -> b_rdata=0xCAFEF00D, collision pulses once; b_re addr 8 concurrently instead -> collision stays 0.
- RD_LATENCY=2: b_re every cycle on addrs 0..9 -> ten consecutive b_rvalid pulses, data in order, starting 2 cycles after the first request.
- Assert reset_n low for one cycle mid-CLEAR (at address 6) and with reads in flight -> no rvalid emitted, CLEAR restarts and runs a full 16 cycles.
- With RAM_PARITY_EN: force a bit flip in a stored byte via the bench backdoor -> a_perr pulses together with a_rvalid; clean reads keep a_perr=0.
